execute_stage_mc: RTL and testbench
===================================

// Module: execute_stage_mc
// PURPOSE
//   Parametrised, registered successor to the LC-3b execute stage.
//   Adds an N-way operand forwarding network, a valid/ready handshake and an
//   EX/MEM output register, plus an iterative multi-cycle multiplier.
//   Sits between decode/regfile read and the memory stage; stalls upstream
//   while the multiplier runs or downstream holds off.
// PARAMETERS
//   WIDTH    16  datapath width (>=4, power of 2)
//   NUM_FWD  3   forwarding sources besides the regfile (e.g. EX/MEM ALU, EX/MEM PC, WB)
// PORTS
//   clk            in   1              clock, rising edge
//   reset          in   1              synchronous, active-high
//   flush          in   1              kill in-flight op and output register (branch taken)
//   in_valid       in   1              upstream presents an op
//   in_ready       out  1              stage accepts an op this cycle
//   op             in   3              0 ADD,1 AND,2 NOT,3 PASSB,4 SLL,5 SRL,6 SRA,7 MUL
//   sr1, sr2       in   WIDTH          regfile operands
//   imm            in   WIDTH          sign/zero-extended immediate (extended upstream)
//   use_imm        in   1              B operand = imm instead of forwarded sr2
//   fwd_data       in   NUM_FWD*WIDTH  forwarding sources; source k at [k*WIDTH +: WIDTH]
//   sr1_fwd_sel    in   FS             FS=$clog2(NUM_FWD+1); 0=sr1, k=fwd source k-1
//   sr2_fwd_sel    in   FS             same encoding for sr2
//   pc             in   WIDTH          PC of the op
//   br_offset      in   WIDTH          sign-extended word offset
//   out_valid      out  1              output register holds a result
//   out_ready      in   1              downstream consumes the result
//   out_result     out  WIDTH          ALU/MUL result
//   out_br_target  out  WIDTH          pc + (br_offset << 1), mod 2^WIDTH
//   out_pc         out  WIDTH          PC of the op
// BEHAVIOUR
//   Reset: state=IDLE, out_valid=0, out_result=0, out_br_target=0, out_pc=0, in_ready=0 during reset.
//   Operands: A = mux(sr1_fwd_sel); B = use_imm ? imm : mux(sr2_fwd_sel).
//     Sel values > NUM_FWD select 0. Forward mux sampled only in the accept cycle.
//   Accept: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
//   Arithmetic, all mod 2^WIDTH: ADD a+b; AND a&b; NOT ~a; PASSB b;
//     SLL/SRL/SRA shift a by b[$clog2(WIDTH)-1:0]; SRA replicates a[WIDTH-1].
//   FSM IDLE:
//     accept non-MUL -> output register loads next edge; out_valid=1; latency 1.
//     accept MUL     -> latch A, B, pc, br_target; counter=0; acc=0; go MUL_BUSY.
//   FSM MUL_BUSY: one shift-add step per cycle (acc += B[i] ? A<<i : 0), WIDTH steps.
//     On the last step, result = low WIDTH bits of the product -> go MUL_DONE.
//   FSM MUL_DONE: load output register when !out_valid || out_ready; out_valid=1; go IDLE.
//     MUL latency, accept to out_valid: WIDTH+1 cycles min; in_ready=0 throughout.
//   Hold: out_valid && !out_ready -> every out_* stable, no new accept.
//   Handoff: out_valid && out_ready with no new result -> out_valid drops next edge.
//     With a simultaneous accept, the register reloads (back-to-back, 1 op/cycle).
//   flush (priority over everything except reset): next edge out_valid=0, state=IDLE,
//     MUL aborted. in_valid in the flush cycle is dropped. Data regs keep stale values.
//   reset mid-MUL: same as flush plus data regs cleared.
//   out_br_target computed in the accept cycle; carry out of the MSB is discarded.
// TESTING
//   ADD sr1=0x1234, sr2=0x0001, sel=0 -> 1 cycle later out_valid=1, out_result=0x1235.
//   Forwarding: sr1_fwd_sel=2, fwd src1=0xBEEF, op=PASSB use_imm imm=0x0005; then
//     op=AND B=0x00FF -> results 0x0005 then 0x00EF.
//   MUL 0x0003*0xFFFF (WIDTH=16) -> in_ready=0 for 17 cycles; out_result=0xFFFD at cycle 17.
//   Stall: out_ready=0 for 5 cycles after a SRA 0x8000 by 3 -> out_result=0xF000
//     held stable; in_ready=0; one transfer when out_ready rises.
//   flush at MUL step 8 -> out_valid never asserts; in_ready=1 next cycle;
//     a following ADD 2+2 -> 0x0004.
//   Branch target pc=0xFFFE, br_offset=0x0002 -> out_br_target=0x0002 (wrap);
//     reset asserted mid-MUL -> all outputs 0 next edge.

Source files
------------

// File: rtl/execute_stage_mc.sv
// rtl/execute_stage_mc.sv - registered execute stage: operand forwarding, ALU,
// iterative shift-add multiplier and EX/MEM output register with valid/ready.
module execute_stage_mc #(
  parameter int WIDTH   = 16,
  parameter int NUM_FWD = 3,
  parameter int FS      = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         sr1,
  input  logic [WIDTH-1:0]         sr2,
  input  logic [WIDTH-1:0]         imm,
  input  logic                     use_imm,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  input  logic [FS-1:0]            sr1_fwd_sel,
  input  logic [FS-1:0]            sr2_fwd_sel,
  input  logic [WIDTH-1:0]         pc,
  input  logic [WIDTH-1:0]         br_offset,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [WIDTH-1:0]         out_br_target,
  output logic [WIDTH-1:0]         out_pc
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [2:0] OP_ADD = 3'd0, OP_AND = 3'd1, OP_NOT = 3'd2, OP_PASSB = 3'd3,
                         OP_SLL = 3'd4, OP_SRL = 3'd5, OP_SRA = 3'd6, OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] a_op, b_fwd, b_op, alu_res, br_shift, br_target;
  logic [WIDTH-1:0] mul_a, mul_b, mul_pc, mul_br, acc;
  logic [CW-1:0]    cnt, shamt;
  logic             out_free, accept, is_mul, load_alu, load_mul;

  // Unmatched select codes (beyond NUM_FWD) fall through to zero.
  always_comb begin
    a_op  = '0;
    b_fwd = '0;
    if (sr1_fwd_sel == '0) a_op = sr1;
    if (sr2_fwd_sel == '0) b_fwd = sr2;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (sr1_fwd_sel == FS'(k + 1)) a_op  = fwd_data[k*WIDTH +: WIDTH];
      if (sr2_fwd_sel == FS'(k + 1)) b_fwd = fwd_data[k*WIDTH +: WIDTH];
    end
  end

  assign b_op      = use_imm ? imm : b_fwd;
  assign shamt     = b_op[CW-1:0];
  assign br_shift  = br_offset << 1;
  assign br_target = pc + br_shift;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = a_op + b_op;
      OP_AND:   alu_res = a_op & b_op;
      OP_NOT:   alu_res = ~a_op;
      OP_PASSB: alu_res = b_op;
      OP_SLL:   alu_res = a_op << shamt;
      OP_SRL:   alu_res = a_op >> shamt;
      OP_SRA:   alu_res = WIDTH'($signed(a_op) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  assign out_free = !out_valid || out_ready;
  assign in_ready = !reset && (state == IDLE) && out_free && !flush;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL);
  assign load_alu = accept && !is_mul;
  assign load_mul = (state == MUL_DONE) && out_free && !flush;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
        MUL_BUSY: if (cnt == LAST_STEP) state_next = MUL_DONE;
        MUL_DONE: if (out_free) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_br_target <= '0;
      out_pc        <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_pc        <= '0;
      mul_br        <= '0;
      acc           <= '0;
      cnt           <= '0;
    end else begin
      if (flush)                      out_valid <= 1'b0;
      else if (load_alu || load_mul)  out_valid <= 1'b1;
      else if (out_ready)             out_valid <= 1'b0;

      if (load_alu) begin
        out_result    <= alu_res;
        out_br_target <= br_target;
        out_pc        <= pc;
      end else if (load_mul) begin
        out_result    <= acc;
        out_br_target <= mul_br;
        out_pc        <= mul_pc;
      end

      // One shift-add step per cycle; only the low WIDTH product bits are kept.
      if (accept && is_mul) begin
        mul_a  <= a_op;
        mul_b  <= b_op;
        mul_pc <= pc;
        mul_br <= br_target;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == MUL_BUSY && !flush) begin
        acc <= acc + (mul_b[cnt] ? (mul_a << cnt) : '0);
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// tb/tb_execute_stage_mc.sv - directed-vector self-checking bench for execute_stage_mc.
module tb_execute_stage_mc;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, use_imm, out_valid, out_ready;
  logic [2:0]  op;
  logic [15:0] sr1, sr2, imm, pc, br_offset, out_result, out_br_target, out_pc;
  logic [47:0] fwd_data;
  logic [1:0]  sr1_fwd_sel, sr2_fwd_sel;

  int n_vec = 0;
  int n_err = 0;

  execute_stage_mc #(.WIDTH(16), .NUM_FWD(3)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sr1(sr1), .sr2(sr2), .imm(imm), .use_imm(use_imm), .fwd_data(fwd_data),
    .sr1_fwd_sel(sr1_fwd_sel), .sr2_fwd_sel(sr2_fwd_sel), .pc(pc), .br_offset(br_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_br_target(out_br_target), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] im, input logic ui, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [15:0] p, input logic [15:0] bo);
    op = o; sr1 = a; sr2 = b; imm = im; use_imm = ui;
    sr1_fwd_sel = s1; sr2_fwd_sel = s2; pc = p; br_offset = bo; in_valid = 1'b1;
  endtask

  logic [2:0]  t_op  [6] = '{3'd2, 3'd4, 3'd5, 3'd4, 3'd3, 3'd0};
  logic [15:0] t_a   [6] = '{16'h00FF, 16'h0001, 16'h8000, 16'h0001, 16'h1234, 16'hFFFF};
  logic [15:0] t_b   [6] = '{16'h0000, 16'h0004, 16'h000F, 16'h0013, 16'hA5A5, 16'h0002};
  logic [15:0] t_exp [6] = '{16'hFF00, 16'h0010, 16'h0001, 16'h0008, 16'hA5A5, 16'h0001};

  initial begin
    int  cyc;
    bit  seen;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    fwd_data = {16'h2222, 16'hBEEF, 16'h1111};
    drive(3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0);
    tick; tick;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_result", out_result, 0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1 check("idle_in_ready", in_ready, 1);

    // ADD with regfile operands, then handoff with nothing new
    drive(3'd0, 16'h1234, 16'h0001, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0100, 16'h0010);
    tick; in_valid = 1'b0;
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 16'h1235);
    check("add_br_target", out_br_target, 16'h0120);
    check("add_pc", out_pc, 16'h0100);
    tick;
    check("handoff_drop", out_valid, 0);

    // Forwarding, back-to-back
    drive(3'd3, 16'h0, 16'h0, 16'h0005, 1'b1, 2'd2, 2'd0, 16'h0, 16'h0);
    tick; check("fwd_passb", out_result, 16'h0005);
    drive(3'd1, 16'h0, 16'h00FF, 16'h0, 1'b0, 2'd2, 2'd0, 16'h0, 16'h0);
    tick; check("fwd_and", out_result, 16'h00EF);
    drive(3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd1, 2'd3, 16'h0, 16'h0);
    tick; check("fwd_add_src0_src2", out_result, 16'h3333);
    check("fwd_b2b_valid", out_valid, 1);

    for (int i = 0; i < 6; i++) begin
      drive(t_op[i], t_a[i], t_b[i], 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0);
      tick;
      check($sformatf("alu_vec%0d", i), out_result, t_exp[i]);
    end
    in_valid = 1'b0;
    tick;

    // MUL 3 * 0xFFFF
    drive(3'd7, 16'h0003, 16'hFFFF, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0200, 16'h0004);
    #1 check("mul_accept_ready", in_ready, 1);
    tick; in_valid = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) seen = 1'b1;
      tick; cyc++;
    end
    check("mul_latency", cyc, 17);
    check("mul_in_ready_low", seen, 0);
    check("mul_result", out_result, 16'hFFFD);
    check("mul_br_target", out_br_target, 16'h0208);
    check("mul_pc", out_pc, 16'h0200);
    tick;

    // Stall with a pending op
    out_ready = 1'b0;
    drive(3'd6, 16'h8000, 16'h0003, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0);
    tick;
    check("sra_result", out_result, 16'hF000);
    drive(3'd0, 16'h0001, 16'h0001, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready || out_result !== 16'hF000 || !out_valid) seen = 1'b1;
      tick;
    end
    check("stall_hold", seen, 0);
    check("stall_result", out_result, 16'hF000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 check("stall_transfer", out_valid && out_ready, 1);
    tick;
    check("stall_single_transfer", out_valid, 0);

    // flush at MUL step 8, with a dropped op in the flush cycle
    drive(3'd7, 16'h0005, 16'h0007, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0);
    tick; in_valid = 1'b0;
    repeat (8) tick;
    flush = 1'b1;
    drive(3'd0, 16'h0009, 16'h0009, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0);
    #1 check("flush_cycle_ready", in_ready, 0);
    tick; flush = 1'b0; in_valid = 1'b0;
    #1 check("post_flush_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    check("flush_no_valid", seen, 0);
    drive(3'd0, 16'h0002, 16'h0002, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0);
    tick; in_valid = 1'b0;
    check("post_flush_add", out_result, 16'h0004);

    // Branch target wrap
    drive(3'd0, 16'h0001, 16'h0001, 16'h0, 1'b0, 2'd0, 2'd0, 16'hFFFE, 16'h0002);
    tick; in_valid = 1'b0;
    check("br_wrap", out_br_target, 16'h0002);
    tick;

    // reset mid-MUL
    drive(3'd7, 16'h0003, 16'h0003, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0300, 16'h0001);
    tick; in_valid = 1'b0;
    repeat (5) tick;
    reset = 1'b1;
    tick; reset = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_result", out_result, 0);
    check("rst_mid_br", out_br_target, 0);
    check("rst_mid_pc", out_pc, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    check("rst_mul_aborted", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
